// File: rtl/cache_ctrl_pkg.sv
// Shared types and address helpers for the 4-way, 16-set write-back data cache controller.
package cache_pkg;

  localparam int unsigned SETS     = 16;
  localparam int unsigned WAYS     = 4;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned INDEX_W  = 4;
  localparam int unsigned TAG_W    = 23;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StRefillWait
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:OFFSET_W+INDEX_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Core request port, SRAM/PLRU control and memory port of the cache controller.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic [31:0]        ufp_addr;
  logic [3:0]         ufp_rmask;
  logic [3:0]         ufp_wmask;
  logic               ufp_resp;
  logic [WAYS-1:0]    tag_match;
  logic [INDEX_W-1:0] arr_index;
  logic [1:0]         arr_way;
  logic               data_we;
  logic               data_src;
  logic               tag_we;
  logic               dfp_read;
  logic               dfp_write;
  logic               dfp_addr_sel;
  logic               dfp_resp;
  logic [INDEX_W-1:0] plru_index;
  logic               plru_hit;
  logic [1:0]         plru_hit_way;
  logic [1:0]         plru_replace;

  modport slave (
    input  ufp_addr, ufp_rmask, ufp_wmask, tag_match, dfp_resp, plru_replace,
    output ufp_resp, arr_index, arr_way, data_we, data_src, tag_we,
           dfp_read, dfp_write, dfp_addr_sel, plru_index, plru_hit, plru_hit_way
  );

  modport master (
    output ufp_addr, ufp_rmask, ufp_wmask, tag_match, dfp_resp, plru_replace,
    input  ufp_resp, arr_index, arr_way, data_we, data_src, tag_we,
           dfp_read, dfp_write, dfp_addr_sel, plru_index, plru_hit, plru_hit_way
  );

endinterface

// File: rtl/cache_ctrl_victim_sel.sv
// Victim way choice on a miss: lowest invalid way, else the PLRU replacement way.
module victim_sel (
  input  logic [3:0] valid_row,
  input  logic [1:0] plru_replace,
  output logic [1:0] victim
);

  always_comb begin
    victim = plru_replace;
    for (int w = 3; w >= 0; w--) begin
      if (!valid_row[w]) victim = 2'(w);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Control FSM for the write-back, write-allocate data cache; owns per-line valid/dirty state.
module cache_ctrl #(
  parameter int unsigned SETS     = 16,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned OFFSET_W = 5
) (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.slave bus
);
  import cache_pkg::*;

  localparam int unsigned IdxW = $clog2(SETS);

  state_e state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [1:0]                victim_q, victim_d;
  logic [IdxW-1:0]           idx;
  logic [WAYS-1:0]           valid_row, dirty_row, hit_vec;
  logic [1:0]                hit_way, victim, upd_way;
  logic                      hit, is_write, is_req;
  logic                      set_valid, set_dirty, clr_dirty;

  assign idx            = bus.ufp_addr[OFFSET_W +: IdxW];
  assign bus.arr_index  = idx;
  assign bus.plru_index = idx;

  assign valid_row = valid_q[idx];
  assign dirty_row = dirty_q[idx];
  assign is_write  = |bus.ufp_wmask;
  assign is_req    = is_write || (|bus.ufp_rmask);
  assign hit_vec   = bus.tag_match & valid_row;
  assign hit       = |hit_vec;

  // Several matching ways is a datapath fault; the lowest way is taken.
  always_comb begin
    hit_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 2'(w);
    end
  end

  victim_sel u_victim_sel (
    .valid_row    (valid_row),
    .plru_replace (bus.plru_replace),
    .victim       (victim)
  );

  always_comb begin
    state_d          = state_q;
    victim_d         = victim_q;
    bus.ufp_resp     = 1'b0;
    bus.arr_way      = 2'd0;
    bus.data_we      = 1'b0;
    bus.data_src     = 1'b0;
    bus.tag_we       = 1'b0;
    bus.dfp_read     = 1'b0;
    bus.dfp_write    = 1'b0;
    bus.dfp_addr_sel = 1'b0;
    bus.plru_hit     = 1'b0;
    bus.plru_hit_way = 2'd0;
    set_valid        = 1'b0;
    set_dirty        = 1'b0;
    clr_dirty        = 1'b0;
    upd_way          = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (is_req) state_d = StCompare;
      end
      StCompare: begin
        if (hit) begin
          bus.ufp_resp     = 1'b1;
          bus.plru_hit     = 1'b1;
          bus.plru_hit_way = hit_way;
          bus.arr_way      = hit_way;
          if (is_write) begin
            bus.data_we = 1'b1;
            set_dirty   = 1'b1;
            upd_way     = hit_way;
          end
          state_d = StIdle;
        end else begin
          victim_d = victim;
          state_d  = dirty_row[victim] ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        bus.dfp_write    = 1'b1;
        bus.dfp_addr_sel = 1'b1;
        bus.arr_way      = victim_q;
        if (bus.dfp_resp) begin
          clr_dirty = 1'b1;
          upd_way   = victim_q;
          state_d   = StAllocate;
        end
      end
      StAllocate: begin
        bus.dfp_read = 1'b1;
        bus.arr_way  = victim_q;
        if (bus.dfp_resp) begin
          bus.data_we  = 1'b1;
          bus.data_src = 1'b1;
          bus.tag_we   = 1'b1;
          set_valid    = 1'b1;
          clr_dirty    = 1'b1;
          upd_way      = victim_q;
          state_d      = StRefillWait;
        end
      end
      // SRAMs need a cycle to re-read the refilled line before the compare hits.
      StRefillWait: state_d = StCompare;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      victim_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_valid) valid_q[idx][upd_way] <= 1'b1;
      if (set_dirty) begin
        dirty_q[idx][upd_way] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_q[idx][upd_way] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, reset/stray-response sequences, random traffic.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Tag SRAM stand-in: written by tag_we, compared against the request tag.
  logic [TAG_W-1:0] tb_tag [SETS][WAYS] = '{default: '0};
  logic [3:0]       tm;
  logic [31:0]      dfp_addr;

  always @(posedge clk) begin
    if (bus.tag_we) tb_tag[bus.arr_index][bus.arr_way] <= addr_tag(bus.ufp_addr);
  end

  always_comb begin
    tm = '0;
    for (int w = 0; w < 4; w++) tm[w] = (tb_tag[bus.arr_index][w] == addr_tag(bus.ufp_addr));
  end
  assign bus.tag_match = tm;

  assign dfp_addr = bus.dfp_addr_sel ?
                    {tb_tag[bus.arr_index][bus.arr_way], bus.arr_index, 5'b0} :
                    {addr_tag(bus.ufp_addr), bus.arr_index, 5'b0};

  // Reference cache contents.
  bit               m_valid [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];

  task automatic model_clear();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [1:0] prep, output logic o_hit, output logic [1:0] o_way,
                        output logic o_wb);
    int               idx, cyc, fill_cyc, resp_cyc, memcnt, lat;
    logic [TAG_W-1:0] tg;
    logic             is_wr, e_hit, e_wb, done;
    logic [1:0]       e_way;
    logic [31:0]      e_wbaddr;

    idx   = int'(addr_index(a));
    tg    = addr_tag(a);
    is_wr = (wm != 4'd0);
    e_hit = 1'b0;
    e_way = prep;
    for (int w = 3; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) begin
        e_hit = 1'b1;
        e_way = w[1:0];
      end
    if (!e_hit)
      for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) e_way = w[1:0];
    e_wb     = !e_hit && m_valid[idx][e_way] && m_dirty[idx][e_way];
    e_wbaddr = {m_tag[idx][e_way], idx[3:0], 5'b0};

    lat = int'($urandom_range(0, 3));
    memcnt = 0; cyc = 0; fill_cyc = -10; resp_cyc = -1; done = 1'b0;
    o_hit = 1'b1; o_way = 2'd0; o_wb = 1'b0;

    @(negedge clk);
    bus.ufp_addr     = a;
    bus.ufp_rmask    = rm;
    bus.ufp_wmask    = wm;
    bus.plru_replace = prep;
    #1;
    chk("idle_no_resp", bus.ufp_resp, 0);
    chk("arr_index", bus.arr_index, idx);

    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.dfp_resp = 1'b0;
      if (bus.dfp_read || bus.dfp_write) begin
        if (memcnt == lat) begin
          bus.dfp_resp = 1'b1;
          memcnt = 0;
        end else memcnt++;
      end
      #1;
      if (bus.dfp_read || bus.dfp_write) chk("dfp_excl", bus.dfp_read & bus.dfp_write, 0);
      if (bus.dfp_write) begin
        o_wb = 1'b1;
        chk("wb_sel", bus.dfp_addr_sel, 1);
        chk("wb_way", bus.arr_way, e_way);
        chk("wb_addr", dfp_addr, e_wbaddr);
      end
      if (bus.dfp_read) begin
        o_hit = 1'b0;
        chk("rd_sel", bus.dfp_addr_sel, 0);
        chk("rd_way", bus.arr_way, e_way);
        chk("rd_addr", dfp_addr, {tg, idx[3:0], 5'b0});
        chk("wb_before_rd", o_wb, e_wb);
        if (bus.dfp_resp) begin
          chk("fill_strobes", {bus.tag_we, bus.data_we, bus.data_src}, 3'b111);
          fill_cyc = cyc;
        end
      end else if (!bus.ufp_resp) begin
        chk("quiet_strobes", {bus.tag_we, bus.data_we, bus.plru_hit}, 0);
      end
      if (bus.ufp_resp) begin
        done     = 1'b1;
        resp_cyc = cyc;
        o_way    = bus.plru_hit_way;
        chk("plru_hit", bus.plru_hit, 1);
        chk("resp_arr_way", bus.arr_way, e_way);
        chk("plru_index", bus.plru_index, idx);
        chk("resp_strobes", {bus.data_we, bus.data_src, bus.tag_we}, {is_wr, 2'b00});
        chk("resp_dfp_idle", {bus.dfp_read, bus.dfp_write}, 0);
      end
    end
    chk("resp_seen", done, 1);
    chk("latency", resp_cyc, e_hit ? 1 : fill_cyc + 2);
    chk("hit", o_hit, e_hit);
    chk("way", o_way, e_way);
    chk("wb", o_wb, e_wb);

    @(negedge clk);
    bus.dfp_resp  = 1'b0;
    bus.ufp_rmask = 4'd0;
    bus.ufp_wmask = 4'd0;
    #1;
    chk("post_idle", {bus.ufp_resp, bus.dfp_read, bus.dfp_write, bus.plru_hit,
                      bus.data_we, bus.tag_we}, 0);

    m_valid[idx][e_way] = 1;
    m_tag[idx][e_way]   = tg;
    if (!e_hit) m_dirty[idx][e_way] = 0;
    if (is_wr)  m_dirty[idx][e_way] = 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [1:0]  prep;
    logic        hit;
    logic [1:0]  way;
    logic        wb;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic       h, wb;
    logic [1:0] wy;

    tbl[0]  = '{32'h0000_0040, 4'hF, 4'h0, 2'd0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{32'h0000_0040, 4'hF, 4'h0, 2'd3, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{32'h0000_0040, 4'h0, 4'h3, 2'd3, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{32'h0000_0240, 4'hF, 4'h0, 2'd0, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{32'h0000_0440, 4'hF, 4'h0, 2'd0, 1'b0, 2'd2, 1'b0};
    tbl[5]  = '{32'h0000_0640, 4'h1, 4'h0, 2'd0, 1'b0, 2'd3, 1'b0};
    tbl[6]  = '{32'h0000_0840, 4'hF, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[7]  = '{32'h0000_0040, 4'hF, 4'h0, 2'd2, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{32'h0000_0244, 4'h0, 4'hF, 2'd0, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{32'h0000_0A40, 4'hF, 4'h0, 2'd1, 1'b0, 2'd1, 1'b1};
    tbl[10] = '{32'h0000_0840, 4'hF, 4'h0, 2'd3, 1'b1, 2'd0, 1'b0};

    bus.ufp_addr     = 32'h0000_01E0;
    bus.ufp_rmask    = 4'd0;
    bus.ufp_wmask    = 4'd0;
    bus.dfp_resp     = 1'b0;
    bus.plru_replace = 2'd0;
    model_clear();

    #12;
    chk("rst_outputs", {bus.ufp_resp, bus.arr_way, bus.data_we, bus.data_src, bus.tag_we,
                        bus.dfp_read, bus.dfp_write, bus.dfp_addr_sel, bus.plru_hit,
                        bus.plru_hit_way}, 0);
    chk("rst_arr_index", bus.arr_index, 4'hF);
    chk("rst_plru_index", bus.plru_index, 4'hF);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].prep, h, wy, wb);
      chk($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
      chk($sformatf("tbl%0d_way", i), wy, tbl[i].way);
      chk($sformatf("tbl%0d_wb", i), wb, tbl[i].wb);
    end

    // Reset while a refill read is outstanding.
    @(negedge clk);
    bus.ufp_addr     = 32'h1000_0060;
    bus.ufp_rmask    = 4'hF;
    bus.plru_replace = 2'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.dfp_read) break;
    end
    #1;
    chk("alloc_reached", bus.dfp_read, 1);
    rst = 1'b0;
    #1;
    chk("rst_drops_dfp", {bus.dfp_read, bus.dfp_write, bus.ufp_resp, bus.tag_we}, 0);
    model_clear();
    @(negedge clk);
    bus.ufp_rmask = 4'd0;
    rst = 1'b1;
    do_req(32'h0000_0040, 4'hF, 4'h0, 2'd3, h, wy, wb);
    chk("post_rst_miss", h, 0);
    chk("post_rst_way", wy, 0);

    // Stray memory response while idle.
    @(negedge clk);
    bus.dfp_resp = 1'b1;
    #1;
    chk("stray_resp_a", {bus.ufp_resp, bus.dfp_read, bus.dfp_write, bus.data_we, bus.tag_we,
                         bus.plru_hit}, 0);
    @(negedge clk);
    bus.dfp_resp = 1'b0;
    #1;
    chk("stray_resp_b", {bus.ufp_resp, bus.dfp_read, bus.dfp_write, bus.data_we, bus.tag_we,
                         bus.plru_hit}, 0);
    do_req(32'h0000_0040, 4'h0, 4'h8, 2'd2, h, wy, wb);
    chk("stray_then_hit", h, 1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [3:0]  rm, wm;
      a  = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 5'($urandom)};
      rm = 4'd0;
      wm = 4'd0;
      if ($urandom_range(0, 1) == 1) wm = 4'($urandom_range(1, 15));
      else rm = 4'($urandom_range(1, 15));
      do_req(a, rm, wm, 2'($urandom), h, wy, wb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
